// File: rtl/arbiter_pkg.sv
// arbiter_pkg: shared FSM encodings and port indices for memory_arbiter.
package arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY    = 2'b01,
    RELEASE = 2'b10
  } state_t;
  localparam logic PORT_INSTR = 1'b0;
  localparam logic PORT_DATA  = 1'b1;
endpackage

// File: rtl/arbiter_picker.sv
// arbiter_picker: combinational winner selection between the two requesters.
// MEMORY_ARBITER_ROUND_ROBIN_EN selects round-robin; otherwise port 1 has fixed priority.
module arbiter_picker
  import arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       lastServed,
  output logic       winner
);
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  always_comb winner = (&req) ? ~lastServed : (req[1] ? PORT_DATA : PORT_INSTR);
`else
  logic unused_last;
  assign unused_last = lastServed;
  always_comb winner = req[1] ? PORT_DATA : PORT_INSTR;
`endif
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one memory port between instruction (0) and data (1) caches.
// Define MEMORY_ARBITER_ROUND_ROBIN_EN for round-robin contention; default is fixed priority to port 1.
module memory_arbiter
  import arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] p0Address,
  input  logic                  p0ReadEnable,
  input  logic                  p0WriteEnable,
  input  logic [DATA_WIDTH-1:0] p0DataIn,
  output logic [DATA_WIDTH-1:0] p0DataOut,
  output logic                  p0Ready,
  input  logic [ADDR_WIDTH-1:0] p1Address,
  input  logic                  p1ReadEnable,
  input  logic                  p1WriteEnable,
  input  logic [DATA_WIDTH-1:0] p1DataIn,
  output logic [DATA_WIDTH-1:0] p1DataOut,
  output logic                  p1Ready,
  output logic [ADDR_WIDTH-1:0] memoryAddress,
  output logic [DATA_WIDTH-1:0] memoryDataOut,
  output logic                  memoryReadEnable,
  output logic                  memoryWriteEnable,
  input  logic [DATA_WIDTH-1:0] memoryDataIn,
  input  logic                  memoryReady
);
  state_t state;
  logic grant, lastServed, winner, busy, g_re, g_we;
  logic [1:0] req;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_data;
  assign req = {p1ReadEnable | p1WriteEnable, p0ReadEnable | p0WriteEnable};
  arbiter_picker u_picker (
    .req       (req),
    .lastServed(lastServed),
    .winner    (winner)
  );
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  always_ff @(posedge clk)
    if (reset) lastServed <= PORT_DATA;
    else if (state == BUSY && memoryReady) lastServed <= grant;
`else
  assign lastServed = PORT_DATA;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= PORT_INSTR;
    end else begin
      case (state)
        IDLE: if (|req) begin
          grant <= winner;
          state <= BUSY;
        end
        BUSY: if (memoryReady) state <= RELEASE;
        default: state <= IDLE;
      endcase
    end
  end
  // Memory side is a pure decode of the registered grant; write masks a simultaneous read.
  always_comb begin
    busy              = state == BUSY;
    g_addr            = grant ? p1Address : p0Address;
    g_data            = grant ? p1DataIn : p0DataIn;
    g_re              = grant ? p1ReadEnable : p0ReadEnable;
    g_we              = grant ? p1WriteEnable : p0WriteEnable;
    memoryAddress     = busy ? g_addr : '0;
    memoryDataOut     = busy ? g_data : '0;
    memoryWriteEnable = busy & g_we;
    memoryReadEnable  = busy & g_re & ~g_we;
    p0DataOut         = (busy && grant == PORT_INSTR) ? memoryDataIn : '0;
    p1DataOut         = (busy && grant == PORT_DATA) ? memoryDataIn : '0;
    p0Ready           = busy & (grant == PORT_INSTR) & memoryReady;
    p1Ready           = busy & (grant == PORT_DATA) & memoryReady;
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed self-checking bench for memory_arbiter.
module tb_memory_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] p0Address, p1Address, p0DataIn, p1DataIn, p0DataOut, p1DataOut;
  logic        p0ReadEnable, p0WriteEnable, p1ReadEnable, p1WriteEnable, p0Ready, p1Ready;
  logic [31:0] memoryAddress, memoryDataOut, memoryDataIn;
  logic        memoryReadEnable, memoryWriteEnable, memoryReady;
  int checks = 0;
  int errors = 0;
  int re_cycles;
  logic exp_g [3];
  memory_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .p0Address        (p0Address),
    .p0ReadEnable     (p0ReadEnable),
    .p0WriteEnable    (p0WriteEnable),
    .p0DataIn         (p0DataIn),
    .p0DataOut        (p0DataOut),
    .p0Ready          (p0Ready),
    .p1Address        (p1Address),
    .p1ReadEnable     (p1ReadEnable),
    .p1WriteEnable    (p1WriteEnable),
    .p1DataIn         (p1DataIn),
    .p1DataOut        (p1DataOut),
    .p1Ready          (p1Ready),
    .memoryAddress    (memoryAddress),
    .memoryDataOut    (memoryDataOut),
    .memoryReadEnable (memoryReadEnable),
    .memoryWriteEnable(memoryWriteEnable),
    .memoryDataIn     (memoryDataIn),
    .memoryReady      (memoryReady)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic clear_reqs();
    p0ReadEnable = 0; p0WriteEnable = 0; p1ReadEnable = 0; p1WriteEnable = 0;
  endtask
  initial begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    exp_g = '{1'b0, 1'b1, 1'b0};
`else
    exp_g = '{1'b1, 1'b1, 1'b1};
`endif
    reset = 1; clear_reqs();
    p0Address = 0; p1Address = 0; p0DataIn = 0; p1DataIn = 0;
    memoryDataIn = 0; memoryReady = 0;
    tick(); tick();
    check("rst_re", memoryReadEnable, 0);
    check("rst_we", memoryWriteEnable, 0);
    check("rst_addr", memoryAddress, 0);
    check("rst_rdy", {p0Ready, p1Ready}, 0);
    reset = 0;
    // port 0 read, memory completes on second BUSY cycle
    re_cycles = 0;
    p0ReadEnable = 1; p0Address = 32'h40; #1;
    check("t1_idle_re", memoryReadEnable, 0);
    tick(); #1;
    re_cycles += int'(memoryReadEnable);
    check("t1_re", memoryReadEnable, 1);
    check("t1_addr", memoryAddress, 32'h40);
    check("t1_rdy_early", p0Ready, 0);
    tick();
    memoryReady = 1; memoryDataIn = 32'hDEADBEEF; #1;
    re_cycles += int'(memoryReadEnable);
    check("t1_p0rdy", p0Ready, 1);
    check("t1_p0data", p0DataOut, 32'hDEADBEEF);
    check("t1_p1rdy", p1Ready, 0);
    check("t1_p1data", p1DataOut, 0);
    tick();
    clear_reqs(); memoryReady = 0; #1;
    re_cycles += int'(memoryReadEnable);
    check("t1_rel_re", memoryReadEnable, 0);
    check("t1_re_cycles", re_cycles, 2);
    tick();
    // port 1 write, memory completes on first BUSY cycle
    p1WriteEnable = 1; p1Address = 32'h80; p1DataIn = 32'h12345678;
    tick();
    memoryReady = 1; #1;
    check("t2_we", memoryWriteEnable, 1);
    check("t2_re", memoryReadEnable, 0);
    check("t2_wdata", memoryDataOut, 32'h12345678);
    check("t2_addr", memoryAddress, 32'h80);
    check("t2_p1rdy", p1Ready, 1);
    check("t2_p0rdy", p0Ready, 0);
    tick();
    clear_reqs(); memoryReady = 0; #1;
    check("t2_rel_we", memoryWriteEnable, 0);
    check("t2_rel_wdata", memoryDataOut, 0);
    tick();
    // contention three times from a fresh reset
    reset = 1; tick(); reset = 0;
    for (int r = 0; r < 3; r++) begin
      p0ReadEnable = 1; p0Address = 32'h100;
      p1ReadEnable = 1; p1Address = 32'h200;
      tick();
      memoryReady = 1; #1;
      check($sformatf("t3_addr%0d", r), memoryAddress, exp_g[r] ? 32'h200 : 32'h100);
      check($sformatf("t3_rdy%0d", r), {p1Ready, p0Ready}, exp_g[r] ? 2'b10 : 2'b01);
      tick();
      clear_reqs(); memoryReady = 0;
      tick();
    end
    // read and write together: write wins
    p1ReadEnable = 1; p1WriteEnable = 1; p1Address = 32'h10; p1DataIn = 32'hA5A5;
    tick(); #1;
    check("t4_we", memoryWriteEnable, 1);
    check("t4_re", memoryReadEnable, 0);
    check("t4_addr", memoryAddress, 32'h10);
    memoryReady = 1;
    tick();
    clear_reqs(); memoryReady = 0;
    tick();
    // reset in the middle of BUSY abandons the access
    p0ReadEnable = 1; p0Address = 32'h44;
    tick(); #1;
    check("t5_busy_re", memoryReadEnable, 1);
    reset = 1;
    tick();
    memoryReady = 1; #1;
    check("t5_re", memoryReadEnable, 0);
    check("t5_we", memoryWriteEnable, 0);
    check("t5_addr", memoryAddress, 0);
    check("t5_p0rdy", p0Ready, 0);
    reset = 0; clear_reqs(); memoryReady = 0;
    tick();
    // memoryReady stuck high: enables follow 1-on/2-off
    memoryReady = 1; p0ReadEnable = 1; p0Address = 32'h8; #1;
    check("t6_idle_rdy", p0Ready, 0);
    for (int i = 0; i < 9; i++) begin
      tick(); #1;
      check($sformatf("t6_re%0d", i), memoryReadEnable, (i % 3) == 0);
    end
    clear_reqs(); memoryReady = 0;
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
